// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle RV32I main controller.
//   - state_t    : controller states (S_TRAP exists only with MC_CTRL_TRAP_EN)
//   - OPC_*      : RV32I major opcode constants (IR[6:0])
//   - datapath mux select encodings (result_src, alu_src_a/b, alu_op, imm_src)
// Optional feature macro: MC_CTRL_TRAP_EN (adds the S_TRAP state).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_JAL,
        S_JALR,
        S_JALR_LINK,
        S_BRANCH,
        S_LUI
`ifdef MC_CTRL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

endpackage

// File: rtl/imm_src_dec.sv
// imm_src_dec: combinational opcode -> immediate format decode.
// Ports:
//   opcode  in  7  IR[6:0]
//   imm_src out 3  immediate format (I/S/B/U/J); opcodes without an
//                  immediate decode to I, which is harmless to the datapath.
module imm_src_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OPC_STORE:           imm_src = IMM_S;
            OPC_BRANCH:          imm_src = IMM_B;
            OPC_LUI, OPC_AUIPC:  imm_src = IMM_U;
            OPC_JAL:             imm_src = IMM_J;
            default:             imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main controller for the RV32I core.
// Moore FSM driving the shared datapath's mux selects and write enables,
// one instruction at a time. Only FETCH's ir_write/pc_update and BRANCH's
// pc_write look at inputs (mem_ready / branch_taken).
// Ports:
//   clk, reset (sync, active-high; forces every output to 0 while high)
//   opcode, branch_taken, mem_ready                     inputs
//   mem_req, mem_we, adr_src                            memory port control
//   ir_write, pc_write, reg_write                       write enables
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src   datapath selects
//   illegal_instr                                       sticky trap flag
// Optional feature macro: MC_CTRL_TRAP_EN -- unknown opcodes park the FSM in
// S_TRAP with illegal_instr=1 until reset; without it they execute as NOPs
// and the illegal_instr port does not exist.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src
`ifdef MC_CTRL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    state_t     state, state_nxt;
    logic       pc_update, branch;
    logic [2:0] imm_dec;

    imm_src_dec u_imm_src_dec (
        .opcode  (opcode),
        .imm_src (imm_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALU_ADD;
        imm_src    = imm_dec;
`ifdef MC_CTRL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC while IR latches.
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative OldPC+imm into ALUOut (branch/JAL/AUIPC target).
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OPC_LOAD, OPC_STORE:     state_nxt = S_MEMADR;
                    OPC_OP:                  state_nxt = S_EXEC_R;
                    OPC_OP_IMM:              state_nxt = S_EXEC_I;
                    OPC_JAL:                 state_nxt = S_JAL;
                    OPC_JALR:                state_nxt = S_JALR;
                    OPC_BRANCH:              state_nxt = S_BRANCH;
                    OPC_LUI:                 state_nxt = S_LUI;
                    OPC_AUIPC:               state_nxt = S_ALUWB;
                    OPC_FENCE, OPC_SYSTEM:   state_nxt = S_FETCH;
`ifdef MC_CTRL_TRAP_EN
                    default:                 state_nxt = S_TRAP;
`else
                    default:                 state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                state_nxt = (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                alu_op    = ALU_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target from DECODE); ALU forms OldPC+4 for ALUWB.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                state_nxt  = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                state_nxt  = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                // Link after the jump: RegA already held rs1, so rd==rs1 is safe.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_REGB;
                alu_op     = ALU_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_LUI: begin
                result_src = RES_IMMEXT;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_nxt     = S_TRAP;
            end
`endif
            default: state_nxt = S_FETCH;
        endcase

        pc_write = pc_update | (branch & branch_taken);

        // Reset dominates combinationally so an in-flight request drops in
        // the very cycle reset is seen, not one cycle later.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            imm_src    = 3'b000;
`ifdef MC_CTRL_TRAP_EN
            illegal_instr = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench for mc_control_fsm. Each driven cycle
// pushes the expected output vector; a negedge monitor pops and compares.
// Build with +define+MC_CTRL_TRAP_EN to exercise the trap variant.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       ill;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .adr_src      (adr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .result_src   (result_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .imm_src      (imm_src)
`ifdef MC_CTRL_TRAP_EN
        ,
        .illegal_instr(ill)
`endif
    );

`ifndef MC_CTRL_TRAP_EN
    assign ill = 1'b0;
`endif

    // {ill, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, alu_op, imm_src}
    logic [17:0] obs;
    assign obs = {ill, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, imm_src};

    int n_cmp = 0;
    int n_bad = 0;
    string       tag_q[$];
    logic [17:0] exp_q[$];

    task automatic chk(input string tag, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end

    function automatic logic [17:0] ov(input logic il, mrq, mwe, adr, irw, pcw, rw,
                                       input logic [1:0] rs, sa, sb, op,
                                       input logic [2:0] imm);
        return {il, mrq, mwe, adr, irw, pcw, rw, rs, sa, sb, op, imm};
    endfunction

    // Per-state expectations written straight from the state table.
    function automatic logic [17:0] e_fetch(input logic rdy, input logic [2:0] imm);
        return ov(0, 1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm);
    endfunction
    function automatic logic [17:0] e_dec(input logic [2:0] imm);
        return ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm);
    endfunction
    function automatic logic [17:0] e_aluwb(input logic [2:0] imm);
        return ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm);
    endfunction

    // One cycle: drive inputs and queue what the outputs must be this cycle.
    task automatic cyc(input string tag, input logic rdy, input logic bt, input logic [17:0] e);
        mem_ready    = rdy;
        branch_taken = bt;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 7'b0110011; branch_taken = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst0", 1, 1, '0);
        cyc("rst1", 1, 1, '0);
        reset = 1'b0;

        // add x3,x1,x2
        opcode = 7'b0110011;
        cyc("add_f",  1, 0, e_fetch(1, 3'b000));
        cyc("add_d",  1, 0, e_dec(3'b000));
        cyc("add_ex", 1, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000));
        cyc("add_wb", 1, 0, e_aluwb(3'b000));

        // lw with two wait cycles in FETCH and MEMREAD: 9 cycles
        opcode = 7'b0000011;
        cyc("lw_fw0", 0, 0, e_fetch(0, 3'b000));
        cyc("lw_fw1", 0, 0, e_fetch(0, 3'b000));
        cyc("lw_f",   1, 0, e_fetch(1, 3'b000));
        cyc("lw_d",   1, 0, e_dec(3'b000));
        cyc("lw_adr", 1, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
        cyc("lw_rw0", 0, 0, ov(0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        cyc("lw_rw1", 0, 0, ov(0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        cyc("lw_rd",  1, 0, ov(0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        cyc("lw_wb",  1, 0, ov(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));

        // beq taken, then not taken
        opcode = 7'b1100011;
        for (int t = 1; t >= 0; t--) begin
            cyc("beq_f", 1, t[0], e_fetch(1, 3'b010));
            cyc("beq_d", 1, t[0], e_dec(3'b010));
            cyc(t[0] ? "beq_tk" : "beq_nt", 1, t[0],
                ov(0, 0, 0, 0, 0, t[0], 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010));
        end

        // jalr x1,0(x1)
        opcode = 7'b1100111;
        cyc("jalr_f",  1, 0, e_fetch(1, 3'b000));
        cyc("jalr_d",  1, 0, e_dec(3'b000));
        cyc("jalr_j",  1, 0, ov(0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 3'b000));
        cyc("jalr_lk", 1, 0, ov(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000));

        // jal: FETCH, DECODE, JAL, ALUWB
        opcode = 7'b1101111;
        cyc("jal_f",  1, 0, e_fetch(1, 3'b100));
        cyc("jal_d",  1, 0, e_dec(3'b100));
        cyc("jal_j",  1, 0, ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b100));
        cyc("jal_wb", 1, 0, e_aluwb(3'b100));

        // addi
        opcode = 7'b0010011;
        cyc("addi_f",  1, 0, e_fetch(1, 3'b000));
        cyc("addi_d",  1, 0, e_dec(3'b000));
        cyc("addi_ex", 1, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000));
        cyc("addi_wb", 1, 0, e_aluwb(3'b000));

        // lui, auipc (3 cycles each), fence (NOP)
        opcode = 7'b0110111;
        cyc("lui_f",  1, 0, e_fetch(1, 3'b011));
        cyc("lui_d",  1, 0, e_dec(3'b011));
        cyc("lui_wb", 1, 0, ov(0, 0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b011));
        opcode = 7'b0010111;
        cyc("auipc_f",  1, 0, e_fetch(1, 3'b011));
        cyc("auipc_d",  1, 0, e_dec(3'b011));
        cyc("auipc_wb", 1, 0, e_aluwb(3'b011));
        opcode = 7'b0001111;
        cyc("fence_f", 1, 0, e_fetch(1, 3'b000));
        cyc("fence_d", 1, 0, e_dec(3'b000));

        // sw, then reset in the MEMWRITE wait
        opcode = 7'b0100011;
        cyc("sw_f",   1, 0, e_fetch(1, 3'b001));
        cyc("sw_d",   1, 0, e_dec(3'b001));
        cyc("sw_adr", 1, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001));
        cyc("sw_wr0", 0, 0, ov(0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001));
        reset = 1'b1;
        cyc("sw_rst", 1, 0, '0);
        reset = 1'b0;
        cyc("sw_ref", 0, 0, e_fetch(0, 3'b001));
        cyc("sw_ref1", 1, 0, e_fetch(1, 3'b001));

        // unknown opcode 0000000
        opcode = 7'b0000000;
        cyc("ill_d", 1, 0, e_dec(3'b000));
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 3; i++)
            cyc("trap", 1, 1, ov(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        reset = 1'b1;
        cyc("trap_rst", 1, 0, '0);
        reset = 1'b0;
        cyc("trap_f", 1, 0, e_fetch(1, 3'b000));
`else
        cyc("ill_f", 1, 0, e_fetch(1, 3'b000));
        cyc("ill_d2", 1, 0, e_dec(3'b000));
        cyc("ill_f2", 0, 0, e_fetch(0, 3'b000));
`endif

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
